// File: rtl/mc_controller_fsm.sv
// Multicycle MIPS control unit with extended opcodes, a memory-ready handshake with timeout,
// a sticky trap state and a retired-instruction counter.
module mc_controller_fsm #(
   parameter int ENABLE_EXT  = 1,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             BranchNe,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       MemtoReg,
   output logic [1:0]       RegDst,
   output logic [1:0]       PCSource,
   output logic [2:0]       ALUSrcB,
   output logic [2:0]       ALUOp,
   output logic             trap,
   output logic [1:0]       trap_code,
   output logic             instr_done,
   output logic [CNT_W-1:0] retired_cnt,
   output logic [4:0]       state_o
);

   // state   | meaning
   // INIT    | post-reset, one cycle
   // FETCH   | read instruction, PC <= PC+4 when mem_ready
   // DECODE  | branch target precompute, dispatch on opcode
   // MADDR   | load/store address compute
   // MEMLW   | load data read, waits for mem_ready
   // MEMR    | load writeback from MDR
   // MEMSW   | store write, waits for mem_ready
   // EXEC    | R-type ALU operation
   // RCOMP   | R-type writeback to rd
   // BRANCH  | BEQ/BNE compare and conditional PC update
   // JUMP    | J target to PC
   // IMM_ALU | immediate ALU operation
   // IMM_WB  | immediate writeback to rt
   // JAL     | jump and link PC+4 into $31
   // TRAP    | sticky error, left only by rst
   typedef enum logic [4:0] {
      S_INIT    = 5'd0,
      S_FETCH   = 5'd1,
      S_DECODE  = 5'd2,
      S_MADDR   = 5'd3,
      S_MEMLW   = 5'd4,
      S_MEMR    = 5'd5,
      S_MEMSW   = 5'd6,
      S_EXEC    = 5'd7,
      S_RCOMP   = 5'd8,
      S_BRANCH  = 5'd9,
      S_JUMP    = 5'd10,
      S_IMM_ALU = 5'd11,
      S_IMM_WB  = 5'd12,
      S_JAL     = 5'd13,
      S_TRAP    = 5'd31
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   localparam logic [1:0] TC_NONE    = 2'b00;
   localparam logic [1:0] TC_ILLEGAL = 2'b01;
   localparam logic [1:0] TC_TIMEOUT = 2'b10;

   localparam int   WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic EXT_ON = (ENABLE_EXT != 0);
   localparam logic TO_ON  = (MEM_TIMEOUT > 0);

   state_t             state_q, state_d;
   logic [1:0]         trap_code_q, trap_code_d;
   logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]   retired_cnt_q, retired_cnt_d;
   logic               timeout_c;
   logic               illegal_c;
   logic               mem_wait_c;

   always_comb begin
      timeout_c   = TO_ON && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) && !mem_ready;
      illegal_c   = 1'b0;
      state_d     = state_q;
      trap_code_d = trap_code_q;
      case (state_q)
         S_INIT:    state_d = S_FETCH;
         S_FETCH: begin
            if (mem_ready)      state_d = S_DECODE;
            else if (timeout_c) state_d = S_TRAP;
         end
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW:               state_d = S_MADDR;
               OP_ADDI:                    state_d = S_IMM_ALU;
               OP_R:                       state_d = S_EXEC;
               OP_BEQ:                     state_d = S_BRANCH;
               OP_J:                       state_d = S_JUMP;
               OP_ANDI, OP_ORI, OP_SLTI: begin
                  if (EXT_ON) state_d = S_IMM_ALU;
                  else        illegal_c = 1'b1;
               end
               OP_BNE: begin
                  if (EXT_ON) state_d = S_BRANCH;
                  else        illegal_c = 1'b1;
               end
               OP_JAL: begin
                  if (EXT_ON) state_d = S_JAL;
                  else        illegal_c = 1'b1;
               end
               default:                    illegal_c = 1'b1;
            endcase
            if (illegal_c) begin
               state_d     = S_TRAP;
               trap_code_d = TC_ILLEGAL;
            end
         end
         S_MADDR:   state_d = (opcode == OP_LW) ? S_MEMLW : S_MEMSW;
         S_MEMLW: begin
            if (mem_ready)      state_d = S_MEMR;
            else if (timeout_c) state_d = S_TRAP;
         end
         S_MEMSW: begin
            if (mem_ready)      state_d = S_FETCH;
            else if (timeout_c) state_d = S_TRAP;
         end
         S_IMM_ALU: state_d = S_IMM_WB;
         S_EXEC:    state_d = S_RCOMP;
         S_MEMR, S_RCOMP, S_IMM_WB, S_BRANCH, S_JUMP, S_JAL: state_d = S_FETCH;
         S_TRAP:    state_d = S_TRAP;
         default:   state_d = S_INIT;
      endcase
      // Only the three handshake states can time out; the illegal path sets its own code above.
      if (timeout_c && state_d == S_TRAP && state_q != S_DECODE) trap_code_d = TC_TIMEOUT;

      mem_wait_c = (state_q == S_FETCH || state_q == S_MEMLW || state_q == S_MEMSW) &&
                   (state_d == state_q);
      wait_cnt_d = mem_wait_c ? wait_cnt_q + WAIT_W'(1) : '0;
   end

   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      BranchNe    = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      MemtoReg    = 2'b00;
      RegDst      = 2'b00;
      PCSource    = 2'b00;
      ALUSrcB     = 3'b000;
      ALUOp       = 3'b000;
      instr_done  = 1'b0;
      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 3'b001;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         S_DECODE:  ALUSrcB = 3'b011;
         S_MADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 3'b010;
         end
         S_MEMLW: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEMR: begin
            RegWrite   = 1'b1;
            MemtoReg   = 2'b01;
            instr_done = 1'b1;
         end
         S_MEMSW: begin
            MemWrite   = 1'b1;
            IorD       = 1'b1;
            instr_done = mem_ready;
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = 3'b010;
         end
         S_RCOMP: begin
            RegWrite   = 1'b1;
            RegDst     = 2'b01;
            instr_done = 1'b1;
         end
         S_IMM_ALU: begin
            ALUSrcA = 1'b1;
            case (opcode)
               OP_ANDI: begin ALUSrcB = 3'b100; ALUOp = 3'b011; end
               OP_ORI:  begin ALUSrcB = 3'b100; ALUOp = 3'b100; end
               OP_SLTI: begin ALUSrcB = 3'b010; ALUOp = 3'b101; end
               default: begin ALUSrcB = 3'b010; ALUOp = 3'b000; end
            endcase
         end
         S_IMM_WB: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = 3'b001;
            PCSource    = 2'b01;
            PCWriteCond = 1'b1;
            BranchNe    = (opcode == OP_BNE);
            instr_done  = 1'b1;
         end
         S_JUMP: begin
            PCWrite    = 1'b1;
            PCSource   = 2'b10;
            instr_done = 1'b1;
         end
         S_JAL: begin
            PCWrite    = 1'b1;
            PCSource   = 2'b10;
            RegWrite   = 1'b1;
            RegDst     = 2'b10;
            MemtoReg   = 2'b10;
            instr_done = 1'b1;
         end
         default: ;
      endcase
      retired_cnt_d = retired_cnt_q + CNT_W'(instr_done);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_INIT;
         trap_code_q   <= TC_NONE;
         wait_cnt_q    <= '0;
         retired_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         trap_code_q   <= trap_code_d;
         wait_cnt_q    <= wait_cnt_d;
         retired_cnt_q <= retired_cnt_d;
      end
   end

   assign trap        = (state_q == S_TRAP);
   assign trap_code   = trap_code_q;
   assign retired_cnt = retired_cnt_q;
   assign state_o     = state_q;

endmodule
